// File: rtl/grant_sink.sv
// Terminates the arbiter's 4-phase req/ack handshake, encodes the one-hot select
// into a requester index and queues it in a small FIFO for a valid/ready consumer.
module grant_sink #(
  parameter int input_size  = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_in,
  input  logic [input_size-1:0]         sel_in,
  output logic                          ack_in,
  output logic                          grant_valid,
  input  logic                          grant_ready,
  output logic [$clog2(input_size)-1:0] grant_idx,
  output logic [$clog2(DEPTH):0]        fill,
  output logic [15:0]                   grant_count,
  output logic                          sel_err
);

  localparam int IW = $clog2(input_size);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, ACK} state_t;

  state_t               state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 req_s;
  logic                 sel_onehot;
  logic [IW-1:0]        sel_idx;
  logic                 push, pop, bad_sel, full, empty, ack_next;
  logic [AW:0]          wr_ptr, rd_ptr;
  logic [IW-1:0]        mem [DEPTH];

  // req_in is asynchronous; sel_in is only looked at once req_s is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
  end

  assign req_s      = sync_q[SYNC_STAGES-1];
  assign sel_onehot = (sel_in != '0) && ((sel_in & (sel_in - input_size'(1))) == '0);

  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < input_size; k++)
      if (sel_in[k]) sel_idx = sel_idx | IW'(k);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ack_in <= 1'b0;
    end else begin
      state  <= state_next;
      ack_in <= ack_next;
    end
  end

  // A bad select is still acknowledged so the arbiter can never deadlock on it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_s && (!sel_onehot || !full)) state_next = ACK;
      ACK:  if (!req_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    push     = (state == IDLE) && req_s && sel_onehot && !full;
    bad_sel  = (state == IDLE) && req_s && !sel_onehot;
    ack_next = (state_next == ACK);
  end

  // Pointer MSB separates full from empty; a same-cycle pop never frees room for a push.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && grant_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      grant_count <= '0;
      sel_err     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= sel_idx;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
        grant_count         <= grant_count + 16'd1;
      end
      if (pop)     rd_ptr  <= rd_ptr + (AW+1)'(1);
      if (bad_sel) sel_err <= 1'b1;
    end
  end

  assign grant_valid = !empty;
  assign grant_idx   = mem[rd_ptr[AW-1:0]];
  assign fill        = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_grant_sink.sv
// Bench for grant_sink: a queue-based model of the handshake/FIFO behaviour checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_grant_sink;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_in = 1'b0;
  logic [7:0] sel_in = 8'h00;
  logic       ack_in, grant_valid, grant_ready;
  logic [2:0] grant_idx;
  logic [2:0] fill;
  logic [15:0] grant_count;
  logic       sel_err;

  int checks = 0;
  int errors = 0;

  bit rand_ready_en = 1'b0;
  bit ready_force   = 1'b0;
  bit rand_bit      = 1'b0;

  grant_sink #(.input_size(N), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .sel_in(sel_in), .ack_in(ack_in),
    .grant_valid(grant_valid), .grant_ready(grant_ready), .grant_idx(grant_idx),
    .fill(fill), .grant_count(grant_count), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rand_bit = 1'($urandom_range(0, 1));
  end

  assign grant_ready = rand_ready_en ? rand_bit : ready_force;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: a delayed view of req, a "request acknowledged" flag and a queue.
  int m_q[$];
  bit m_acked;
  int m_count;
  bit m_err;
  bit hist[SYNC];
  bit m_req_s, m_full, m_pop, m_push;
  int m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_acked = 1'b0;
      m_count = 0;
      m_err   = 1'b0;
      foreach (hist[i]) hist[i] = 1'b0;
    end else begin
      m_req_s = hist[SYNC-1];
      m_full  = (m_q.size() == DEPTH);
      m_pop   = (m_q.size() != 0) && (grant_ready === 1'b1);
      m_push  = 1'b0;
      if (!m_acked && m_req_s) begin
        if ($countones(sel_in) != 1) begin
          m_err   = 1'b1;
          m_acked = 1'b1;
        end else if (!m_full) begin
          m_idx = 0;
          for (int k = 0; k < N; k++) if (sel_in[k]) m_idx = k;
          m_push  = 1'b1;
          m_acked = 1'b1;
          m_count = (m_count + 1) % 65536;
        end
      end else if (m_acked && !m_req_s) begin
        m_acked = 1'b0;
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_push) m_q.push_back(m_idx);
      for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = req_in;
    end
  end

  always @(negedge clk) begin
    checkOutput("ack_in", 32'(ack_in), 32'(m_acked));
    checkOutput("grant_valid", 32'(grant_valid), 32'(m_q.size() != 0));
    checkOutput("fill", 32'(fill), 32'(m_q.size()));
    checkOutput("grant_count", 32'(grant_count), 32'(m_count));
    checkOutput("sel_err", 32'(sel_err), 32'(m_err));
    if (m_q.size() != 0) checkOutput("grant_idx", 32'(grant_idx), 32'(m_q[0]));
  end

  task automatic waitAck(input logic level, output int edges);
    edges = 0;
    while (ack_in !== level && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    if (ack_in !== level) checkOutput("ack_timeout", 32'(ack_in), 32'(level));
  endtask

  // One complete 4-phase handshake; returns the edge counts for rise and fall of ack.
  task automatic applyStimulus(input logic [7:0] sel, output int up_edges, output int dn_edges);
    sel_in = sel;
    req_in = 1'b1;
    waitAck(1'b1, up_edges);
    req_in = 1'b0;
    waitAck(1'b0, dn_edges);
  endtask

  task automatic pulseReady();
    ready_force = 1'b1;
    @(posedge clk); #1;
    ready_force = 1'b0;
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete, got 0, expected 1");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int up, dn, popsum;
    logic [7:0] vec;
    int drain_order[4];
    drain_order = '{0, 3, 1, 6};

    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_ack", 32'(ack_in), 0);
    checkOutput("reset_valid", 32'(grant_valid), 0);
    checkOutput("reset_fill", 32'(fill), 0);
    checkOutput("reset_count", 32'(grant_count), 0);
    checkOutput("reset_err", 32'(sel_err), 0);
    checkOutput("reset_idx", 32'(grant_idx), 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single handshake");
    applyStimulus(8'b0010_0000, up, dn);
    checkOutput("single_up_edges", 32'(up), 3);
    checkOutput("single_dn_edges", 32'(dn), 3);
    checkOutput("single_idx", 32'(grant_idx), 5);
    checkOutput("single_valid", 32'(grant_valid), 1);
    checkOutput("single_count", 32'(grant_count), 1);
    pulseReady();
    checkOutput("single_drained", 32'(fill), 0);

    $display("[TB] burst with backpressure");
    applyStimulus(8'b1000_0000, up, dn);
    applyStimulus(8'b0000_0001, up, dn);
    applyStimulus(8'b0000_1000, up, dn);
    applyStimulus(8'b0000_0010, up, dn);
    checkOutput("burst_fill", 32'(fill), 4);
    checkOutput("burst_head", 32'(grant_idx), 7);
    sel_in = 8'b0100_0000;
    req_in = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("burst_stalled_ack", 32'(ack_in), 0);
    pulseReady();
    waitAck(1'b1, up);
    checkOutput("burst_fill_after", 32'(fill), 4);
    req_in = 1'b0;
    waitAck(1'b0, dn);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_order", 32'(grant_idx), 32'(drain_order[i]));
      pulseReady();
    end
    checkOutput("drain_empty", 32'(grant_valid), 0);
    checkOutput("burst_count", 32'(grant_count), 6);

    $display("[TB] bad select");
    applyStimulus(8'b0000_0000, up, dn);
    checkOutput("badsel_zero_err", 32'(sel_err), 1);
    checkOutput("badsel_zero_count", 32'(grant_count), 6);
    applyStimulus(8'b0000_0011, up, dn);
    checkOutput("badsel_multi_err", 32'(sel_err), 1);
    checkOutput("badsel_multi_count", 32'(grant_count), 6);
    checkOutput("badsel_fill", 32'(fill), 0);

    $display("[TB] reset mid-handshake");
    sel_in = 8'b0000_0100;
    req_in = 1'b1;
    waitAck(1'b1, up);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_ack_drop", 32'(ack_in), 0);
    checkOutput("async_fill", 32'(fill), 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    waitAck(1'b1, up);
    checkOutput("dup_fill", 32'(fill), 1);
    checkOutput("dup_idx", 32'(grant_idx), 2);
    checkOutput("dup_count", 32'(grant_count), 1);
    req_in = 1'b0;
    waitAck(1'b0, dn);
    pulseReady();

    $display("[TB] random arbiter replay");
    @(negedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rand_ready_en = 1'b1;
    popsum = 0;
    for (int v = 0; v < 100; v++) begin
      vec = 8'($urandom_range(0, 255));
      popsum += $countones(vec);
      for (int k = 0; k < N; k++)
        if (vec[k]) applyStimulus(8'(1 << k), up, dn);
    end
    rand_ready_en = 1'b0;
    ready_force   = 1'b1;
    repeat (DEPTH + 2) @(posedge clk);
    #1;
    ready_force = 1'b0;
    checkOutput("replay_count", 32'(grant_count), 32'(popsum % 65536));
    checkOutput("replay_err", 32'(sel_err), 0);
    checkOutput("replay_drained", 32'(fill), 0);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grant_sink.md
# grant_sink

Clocked consumer placed directly downstream of the 8-input cascade arbiter. It terminates the arbiter's asynchronous 4-phase req/ack output handshake. It captures the one-hot `sel` vector carried with each request, encodes it to a binary requester index, and queues that index in a small FIFO. A synchronous valid/ready consumer drains the FIFO, and a running grant count plus a sticky protocol-error flag are kept for observability.

## Interface
- `input_size`, default 8: width of `sel_in` (number of arbiter requesters); ≥2.
- `DEPTH`, default 4: FIFO entries; power of 2, ≥2.
- `SYNC_STAGES`, default 2: flops in the `req_in` synchronizer; ≥2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_in`  in  1  request from the arbiter's `req_out`; asynchronous to `clk`.
- `sel_in`  in  input_size  one-hot grant vector from the arbiter; stable from `req_in` rise until `ack_in` fall.
- `ack_in`  out  1  acknowledge to the arbiter's `ack_out`; registered.
- `grant_valid`  out  1  FIFO non-empty.
- `grant_ready`  in  1  consumer accepts the head entry.
- `grant_idx`  out  $clog2(input_size)  binary index of the FIFO head entry.
- `fill`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `grant_count`  out  16  number of entries ever pushed; wraps modulo 2^16.
- `sel_err`  out  1  sticky; set on a non-one-hot `sel_in`.

## Operation
- `req_in` passes through a `SYNC_STAGES`-flop synchronizer, giving `req_s`. `sel_in` is not synchronized. It is sampled only once `req_s` = 1, when it is guaranteed stable.
- FSM states are IDLE and ACK.
- IDLE with `req_s` = 1:
  - If `sel_in` is one-hot and the FIFO is not full: push the index, increment `grant_count`, set `ack_in` = 1, go to ACK.
  - If `sel_in` is not one-hot (zero or multi-hot): set `sel_err`, push nothing, leave the count unchanged, set `ack_in` = 1, go to ACK. This never deadlocks the arbiter.
  - If the FIFO is full and `sel_in` is one-hot: stay in IDLE with `ack_in` = 0 (backpressure).
- ACK: hold `ack_in` = 1 until `req_s` = 0, then set `ack_in` = 0 and go to IDLE. The return-to-zero phase completes the 4-phase cycle.
- IDLE with `req_s` = 0: no action.
- FIFO:
  - Read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB distinguishes full from empty.
  - `grant_idx` shows the head entry combinationally from storage.
  - Pop occurs when `grant_valid` && `grant_ready`.
- Full decisions use the registered full flag of the current cycle. A pop in the same cycle does not enable a push; the push happens on the next cycle.
- Pop while empty is ignored. Simultaneous push and pop (not full, not empty) leaves `fill` unchanged.
- Index encoding: bit k set → index k (LSB is index 0).

## Timing
- Values during and immediately after reset:
  - `ack_in` = 0, `grant_valid` = 0, `fill` = 0, `grant_count` = 0, `sel_err` = 0.
  - FSM in IDLE; synchronizer cleared.
  - `grant_idx` = 0 (storage cleared).
- Request to ack: `ack_in` rises on the (`SYNC_STAGES`+1)th rising edge after `req_in` rises, if not stalled. With defaults this is 3 edges.
- Release to ack drop: `ack_in` falls on the (`SYNC_STAGES`+1)th edge after `req_in` falls.
- Push to output: `grant_valid` goes high in the cycle after the push edge; throughput is 1 pop per cycle.
- Reset mid-handshake:
  - `ack_in` drops immediately (asynchronous) and the FIFO empties.
  - A `req_in` still high after reset release is treated as a new request. It is pushed again; the duplicate is accepted behaviour.
- A full FIFO stalls `ack_in` indefinitely. The ack follows one edge after the first cycle that IDLE sees `req_s` = 1 with not-full.

## Test plan
- Reset check: hold `rst_n` = 0 → every output at its reset value. Drop `rst_n` asynchronously mid-cycle with `ack_in` = 1 → `ack_in` = 0 without a clock edge.
- Single handshake: `sel_in` = 8'b0010_0000, `req_in` ↑ → `ack_in` ↑ at the 3rd edge; `grant_idx` = 5, `grant_valid` = 1, `grant_count` = 1. `req_in` ↓ → `ack_in` ↓ 3 edges later.
- Burst with `grant_ready` = 0: sequential handshakes for indices 7, 0, 3, 1 → `fill` = 4. A 5th request (index 6) gets no ack. Pulse `grant_ready` for one cycle → pop 7, then ack for 6 follows. Drain order is 0, 3, 1, 6.
- Bad select: `sel_in` = 0, then `sel_in` = 8'b0000_0011 → each still acked, no push, `grant_count` unchanged, `sel_err` = 1 and staying set.
- Arbiter replay: drive 100 random 8-bit request vectors through the cascade arbiter into this block, with `grant_ready` toggling randomly → the pushed index sequence matches the arbiter `sel` history, `sel_err` = 0, and `grant_count` equals the total popcount of all vectors mod 2^16.
